pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Merges stall requests from IF/ID/EX/MEM.
//  Owns the EX multi-cycle (div) busy counter and turns MEM-stage exceptions into
//  flush + new_pc. Drives stall[5:0]/flush into pc_reg, if_id, id_ex, ex_mem, mem_wb.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MC_LAT      32            EX multi-cycle op latency in cycles, >=2
//  EXC_VECTOR  32'h0000_0020 exception handler entry address
//  ERET_CODE   32'h0000_000e exc_type value meaning ERET (return to epc)
//  PERF_W      32            width of stall-cycle counter
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst           in   1       asynchronous reset, active-high
//  stallreq_if   in   1       IF requests stall
//  stallreq_id   in   1       ID requests stall (load-use)
//  stallreq_ex   in   1       EX requests stall (single-cycle hazard)
//  stallreq_mem  in   1       MEM requests stall (bus wait)
//  ex_mc_start   in   1       EX issues a multi-cycle op this cycle
//  exc_type      in   32      MEM-stage exception type, 0 = none
//  cp0_epc       in   32      current EPC
//  stall         out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold
//  flush         out  1       clear all pipeline registers this cycle
//  new_pc        out  32      PC to load when flush=1, else 0
//  mc_done       out  1       1-cycle pulse: multi-cycle result valid in EX
//  mc_busy       out  1       1 while state MC_BUSY
//  stall_cycles  out  PERF_W  count of cycles with stall!=0, saturating
// BEHAVIOUR
//  - Reset (rst=1, any time, incl. mid MC_BUSY) -> state RUN, cnt=0, stall_cycles=0.
//    While rst=1 all outputs are 0.
//  - States: RUN, MC_BUSY. cnt width $clog2(MC_LAT+1).
//  - Outputs stall/flush/new_pc/mc_done/mc_busy are combinational from state, cnt, inputs.
//  - Priority, highest first:
//    exception (exc_type!=0)      -> flush=1, stall=0.
//    stallreq_mem                 -> 6'b011111.
//    stallreq_ex or EX busy       -> 6'b001111.
//    stallreq_id                  -> 6'b000111.
//    stallreq_if                  -> 6'b000011.
//    else                         -> 0.
//  - "EX busy" means either (RUN & ex_mc_start) or (MC_BUSY & cnt!=0).
//  - new_pc = cp0_epc if exc_type==ERET_CODE; EXC_VECTOR if exc_type is any other
//    nonzero value; 0 if no exception.
//  - RUN:
//    ex_mc_start & exc_type==0 & !stallreq_mem -> cnt<=MC_LAT-1, state->MC_BUSY.
//    ex_mc_start is ignored in any other RUN cycle.
//  - MC_BUSY:
//    cnt!=0 -> cnt decrements every cycle, even under stallreq_mem.
//    cnt==0 -> mc_done=1, EX stall released, state->RUN.
//    ex_mc_start is ignored.
//  - Timing: start at cycle t -> stall[3]=1 for cycles t..t+MC_LAT-1; mc_done at
//    t+MC_LAT. mc_done is suppressed if exc_type!=0 in that same cycle.
//  - Exception in MC_BUSY -> flush that cycle, cnt<=0, state->RUN; no mc_done.
//  - stall_cycles increments when stall!=0, holds at 2^PERF_W-1. Flush cycles are
//    not counted.
// TESTING
//  1 MC_LAT=4, ex_mc_start at t -> stall=6'b001111 t..t+3; mc_done=1 and stall=0
//    at t+4; mc_busy t+1..t+4.
//  2 MC_BUSY at cnt=2, rst pulsed -> outputs 0 immediately; after release state=RUN,
//    no mc_done.
//  3 stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111. Drop mem ->
//    stall=6'b000111.
//  4 exc_type=32'h1 during MC_BUSY -> flush=1, new_pc=32'h20, stall=0; next cycle
//    mc_busy=0, and no mc_done ever.
//  5 exc_type=ERET_CODE, cp0_epc=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234 in the
//    same cycle.
//  6 PERF_W=4, stallreq_if held 20 cycles -> stall_cycles reaches 15 and stays 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencer for the 5-stage core.
//
// Merges the per-stage stall requests into one stall vector and turns a
// MEM-stage exception into a flush with the redirect PC. It also runs the
// EX multi-cycle (divide) busy counter and keeps a saturating count of
// stalled cycles.
//
// Ports:
//   clk, rst        clock (posedge), asynchronous active-high reset
//   stallreq_if/id/ex/mem  stall requests from each stage
//   ex_mc_start     EX issues a multi-cycle op this cycle
//   exc_type        MEM-stage exception type, 0 = none
//   cp0_epc         current EPC (ERET target)
//   stall[5:0]      hold: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   flush           clear all pipeline registers this cycle
//   new_pc          redirect PC when flush=1, else 0
//   mc_done         1-cycle pulse: multi-cycle result valid in EX
//   mc_busy         1 while the multi-cycle op is in flight
//   stall_cycles    saturating count of cycles with stall != 0
module pipe_ctrl #(
  parameter int unsigned MC_LAT     = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_mc_start,
  input  logic [31:0]       exc_type,
  input  logic [31:0]       cp0_epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_done,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  logic                exc;
  logic                ex_busy;
  logic [5:0]          stall_c;
  logic                flush_c;
  logic [31:0]         new_pc_c;
  logic                mc_done_c;
  logic                mc_busy_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    perf_d    = perf_q;
    stall_c   = 6'b000000;
    flush_c   = 1'b0;
    new_pc_c  = 32'h0;
    mc_done_c = 1'b0;
    mc_busy_c = (state_q == MC_BUSY);

    exc = (exc_type != 32'h0);
    // EX holds on the issue cycle itself and for every counted busy cycle;
    // the cnt==0 cycle is the result cycle and releases EX.
    ex_busy = ((state_q == RUN) && ex_mc_start) ||
              ((state_q == MC_BUSY) && (cnt_q != '0));

    if (exc) begin
      flush_c  = 1'b1;
      new_pc_c = (exc_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
    end else if (stallreq_mem) begin
      stall_c = 6'b011111;
    end else if (stallreq_ex || ex_busy) begin
      stall_c = 6'b001111;
    end else if (stallreq_id) begin
      stall_c = 6'b000111;
    end else if (stallreq_if) begin
      stall_c = 6'b000011;
    end

    case (state_q)
      RUN: begin
        // A start blocked by a bus wait or exception is dropped, not queued.
        if (ex_mc_start && !exc && !stallreq_mem) begin
          cnt_d   = CNT_W'(MC_LAT - 1);
          state_d = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (exc) begin
          // Exception kills the in-flight op: no result pulse.
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q != '0) begin
          // Keeps counting under a MEM bus wait; the divider is free-running.
          cnt_d = cnt_q - 1'b1;
        end else begin
          mc_done_c = 1'b1;
          state_d   = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // stall_c is zero on flush cycles, so those are never counted.
    if ((stall_c != 6'b000000) && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  // Combinational outputs are forced low for the whole time reset is held.
  assign stall        = rst ? 6'b000000 : stall_c;
  assign flush        = rst ? 1'b0 : flush_c;
  assign new_pc       = rst ? 32'h0 : new_pc_c;
  assign mc_done      = rst ? 1'b0 : mc_done_c;
  assign mc_busy      = rst ? 1'b0 : mc_busy_c;
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MC_LAT=4, PERF_W=4).
// Inputs change at the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge that updates state.
module tb_pipe_ctrl;

  localparam int unsigned MC_LAT = 4;
  localparam int unsigned PERF_W = 4;

  logic              clk;
  logic              rst;
  logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic              ex_mc_start;
  logic [31:0]       exc_type;
  logic [31:0]       cp0_epc;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_done;
  logic              mc_busy;
  logic [PERF_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .MC_LAT    (MC_LAT),
    .EXC_VECTOR(32'h0000_0020),
    .ERET_CODE (32'h0000_000e),
    .PERF_W    (PERF_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .ex_mc_start (ex_mc_start),
    .exc_type    (exc_type),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .mc_done     (mc_done),
    .mc_busy     (mc_busy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  req;       // {if, id, ex, mem}
    logic        start;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] e_stall, input logic e_flush,
                            input logic [31:0] e_pc, input logic e_done, input logic e_busy);
    chk({tag, ".stall"},   32'(stall),   32'(e_stall));
    chk({tag, ".flush"},   32'(flush),   32'(e_flush));
    chk({tag, ".new_pc"},  new_pc,       e_pc);
    chk({tag, ".mc_done"}, 32'(mc_done), 32'(e_done));
    chk({tag, ".mc_busy"}, 32'(mc_busy), 32'(e_busy));
    $display("%0t %s stall=%b flush=%b new_pc=%h done=%b busy=%b perf=%0d",
             $time, tag, stall, flush, new_pc, mc_done, mc_busy, stall_cycles);
  endtask

  task automatic clear_in();
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
    ex_mc_start = 1'b0;
    exc_type    = 32'h0;
    cp0_epc     = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //           req     st   exc          epc          stall      fl  pc           busy
    vecs[0]  = '{4'b0000, 0, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0};
    vecs[1]  = '{4'b1000, 0, 32'h0,       32'h0,       6'b000011, 0, 32'h0,       0};
    vecs[2]  = '{4'b0100, 0, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0};
    vecs[3]  = '{4'b0010, 0, 32'h0,       32'h0,       6'b001111, 0, 32'h0,       0};
    vecs[4]  = '{4'b0001, 0, 32'h0,       32'h0,       6'b011111, 0, 32'h0,       0};
    vecs[5]  = '{4'b0101, 0, 32'h0,       32'h0,       6'b011111, 0, 32'h0,       0};
    vecs[6]  = '{4'b0100, 0, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0};
    vecs[7]  = '{4'b1100, 0, 32'h0,       32'h0,       6'b000111, 0, 32'h0,       0};
    vecs[8]  = '{4'b1111, 0, 32'h0,       32'h0,       6'b011111, 0, 32'h0,       0};
    // start blocked by MEM wait: still RUN in the following row
    vecs[9]  = '{4'b0001, 1, 32'h0,       32'h0,       6'b011111, 0, 32'h0,       0};
    // start blocked by exception
    vecs[10] = '{4'b1111, 1, 32'h1,       32'h0,       6'b000000, 1, 32'h20,      0};
    vecs[11] = '{4'b0000, 0, 32'h0000_000e, 32'h0000_1234, 6'b000000, 1, 32'h0000_1234, 0};
    vecs[12] = '{4'b0100, 0, 32'h5,       32'h0000_1234, 6'b000000, 1, 32'h20,      0};
    vecs[13] = '{4'b0000, 0, 32'h0,       32'h0,       6'b000000, 0, 32'h0,       0};

    clear_in();
    rst = 1'b1;
    // Reset with active inputs: all outputs must be 0.
    stallreq_mem = 1'b1;
    exc_type     = 32'h1;
    ex_mc_start  = 1'b1;
    @(negedge clk);
    #1 check_outs("reset", 6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.stall_cycles", 32'(stall_cycles), 32'h0);
    clear_in();
    @(negedge clk);
    rst = 1'b0;

    // Combinational priority / new_pc table, all in RUN.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = vecs[i].req;
      ex_mc_start = vecs[i].start;
      exc_type    = vecs[i].exc;
      cp0_epc     = vecs[i].epc;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush,
                    vecs[i].exp_pc, 1'b0, vecs[i].exp_busy);
    end

    // Multi-cycle timing: stall t..t+3, busy t+1..t+4, done at t+4.
    @(negedge clk);
    clear_in();
    ex_mc_start = 1'b1;
    #1 check_outs("mc.t0", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      ex_mc_start = 1'b0;
      #1 check_outs($sformatf("mc.t%0d", i), 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    #1 check_outs("mc.t4", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    #1 check_outs("mc.t5", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // MEM wait during MC_BUSY: counter keeps running, done still at t+4.
    @(negedge clk);
    ex_mc_start = 1'b1;
    #1 check_outs("mcmem.t0", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      ex_mc_start  = 1'b0;
      stallreq_mem = 1'b1;
      #1 check_outs($sformatf("mcmem.t%0d", i), 6'b011111, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    #1 check_outs("mcmem.t4", 6'b011111, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    stallreq_mem = 1'b0;
    #1 check_outs("mcmem.t5", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset pulsed in MC_BUSY at cnt=2.
    @(negedge clk);
    ex_mc_start = 1'b1;
    @(negedge clk);
    ex_mc_start = 1'b0;
    @(negedge clk);
    #1 check_outs("rstmc.pre", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    #1 check_outs("rstmc.in", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 check_outs($sformatf("rstmc.post%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Exception during MC_BUSY: flush, then RUN, never mc_done.
    ex_mc_start = 1'b1;
    @(negedge clk);
    ex_mc_start = 1'b0;
    @(negedge clk);
    exc_type = 32'h1;
    #1 check_outs("excmc.exc", 6'b000000, 1'b1, 32'h20, 1'b0, 1'b1);
    @(negedge clk);
    exc_type = 32'h0;
    for (int i = 0; i < 6; i++) begin
      #1 check_outs($sformatf("excmc.post%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
    end

    // Exception in the result cycle suppresses mc_done.
    ex_mc_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_mc_start = 1'b0;
    end
    exc_type = 32'h0000_000e;
    cp0_epc  = 32'h0000_abcd;
    #1 check_outs("excdone.t4", 6'b000000, 1'b1, 32'h0000_abcd, 1'b0, 1'b1);
    @(negedge clk);
    clear_in();
    #1 check_outs("excdone.t5", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

    // Performance counter: flush cycles not counted, then saturation at 15.
    do_reset();
    stallreq_if = 1'b1;
    exc_type    = 32'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("perf.flush%0d", i), 32'(stall_cycles), 32'h0);
      $display("%0t perf.flush%0d stall_cycles=%0d", $time, i, stall_cycles);
    end
    exc_type = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1 chk($sformatf("perf.k%0d", k), 32'(stall_cycles), 32'((k > 15) ? 15 : k));
      $display("%0t perf.k%0d stall_cycles=%0d", $time, k, stall_cycles);
    end
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
